// File: rtl/pc_stack.sv
// pc_stack: program counter with a small LIFO return-address stack.
// Each enabled edge performs one action in priority order
// call > ret > ld > increment. In halt mode (WRAP_MODE=0) stepping from
// the top address parks the block in HALT with co held high until reset.
// In wrap mode (WRAP_MODE=1) the counter rolls over to 0 and co pulses
// for that one cycle.
//
// Command semantics: en qualifies every command. When en=0 nothing
// changes, except that the wrap-mode co pulse falls back to 0. ld, call
// and ret are levels sampled on each rising edge, not handshakes. A
// command that cannot complete (call while full, ret while empty) leaves
// out and sp unchanged and sets a sticky error flag instead.
module pc_stack #(
  parameter  int ADDR_W    = 4,
  parameter  int DEPTH     = 4,
  parameter  int WRAP_MODE = 0,
  localparam int SP_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ld,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] in,
  output logic [ADDR_W-1:0] out,
  output logic              co,
  output logic [SP_W-1:0]   sp,
  output logic              full,
  output logic              empty,
  output logic              ovf_err,
  output logic              unf_err,
  output logic              state_dbg
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] MAX_PC = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] out_q, out_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              co_q, co_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push;
  logic [ADDR_W-1:0] push_data;
  logic [ADDR_W-1:0] top;
  logic [ADDR_W-1:0] stk [DEPTH];

  assign out       = out_q;
  assign co        = co_q;
  assign sp        = sp_q;
  assign full      = (sp_q == SP_W'(DEPTH));
  assign empty     = (sp_q == '0);
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;
  assign state_dbg = state_q;

  // Select the most recently pushed entry (index sp-1); 0 when empty.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) top = stk[i];
    end
  end

  // Next-state and action decode for one edge.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    sp_d      = sp_q;
    co_d      = (WRAP_MODE == 0) ? co_q : 1'b0;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push      = 1'b0;
    push_data = out_q + ADDR_W'(1);
    if (state_q == RUN && en) begin
      if (WRAP_MODE == 0 && out_q == MAX_PC) begin
        // Top of range: discard any command and park.
        state_d = HALT;
        co_d    = 1'b1;
      end else if (call) begin
        if (!full) begin
          push  = 1'b1;
          out_d = in;
          sp_d  = sp_q + SP_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (ret) begin
        if (!empty) begin
          out_d = top;
          sp_d  = sp_q - SP_W'(1);
        end else begin
          unf_d = 1'b1;
        end
      end else if (ld) begin
        out_d = in;
      end else begin
        out_d = out_q + ADDR_W'(1);
        if (WRAP_MODE != 0 && out_q == MAX_PC) co_d = 1'b1;
      end
    end
  end

  // State, counter, flag and stack registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      out_q   <= '0;
      sp_q    <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      sp_q    <= sp_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (push && sp_q == SP_W'(i)) stk[i] <= push_data;
      end
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// Directed testbench for pc_stack: a halt-mode instance (defaults) and a
// wrap-mode instance share the clock and stimulus.
module tb_pc_stack;

  logic       clk;
  logic       rst;
  logic       en, ld, call, ret;
  logic [3:0] in;
  logic [3:0] out, w_out;
  logic       co, w_co;
  logic [2:0] sp, w_sp;
  logic       full, empty, ovf_err, unf_err, state_dbg;
  logic       w_full, w_empty, w_ovf_err, w_unf_err, w_state_dbg;

  int tests_run;
  int tests_failed;

  pc_stack #(.ADDR_W(4), .DEPTH(4), .WRAP_MODE(0)) dut (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .call(call), .ret(ret),
    .in(in), .out(out), .co(co), .sp(sp), .full(full), .empty(empty),
    .ovf_err(ovf_err), .unf_err(unf_err), .state_dbg(state_dbg)
  );

  pc_stack #(.ADDR_W(4), .DEPTH(4), .WRAP_MODE(1)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .call(call), .ret(ret),
    .in(in), .out(w_out), .co(w_co), .sp(w_sp), .full(w_full),
    .empty(w_empty), .ovf_err(w_ovf_err), .unf_err(w_unf_err),
    .state_dbg(w_state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic e, input logic c, input logic r,
                       input logic l, input logic [3:0] d);
    en = e; call = c; ret = r; ld = l; in = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
    rst = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({out, sp, co, empty, full, ovf_err, unf_err, state_dbg} !== {4'd0, 3'd0, 6'b010000}) begin
      tests_failed++;
      $display("FAIL reset_state: out=%0d sp=%0d co=%b empty=%b full=%b ovf=%b unf=%b st=%b, expected 0 0 0 1 0 0 0 0",
               out, sp, co, empty, full, ovf_err, unf_err, state_dbg);
    end
    tests_run++;
    if ({w_out, w_co} !== {4'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_wrap: out=%0d co=%b, expected 0 0", w_out, w_co);
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_count_halt();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      tests_run++;
      if (out !== 4'(k) || co !== 1'b0) begin
        tests_failed++;
        $display("FAIL count_step%0d: out=%0d co=%b, expected %0d 0", k, out, co, k);
      end
    end
    tick();
    tests_run++;
    if (out !== 4'd15 || co !== 1'b1 || state_dbg !== 1'b1) begin
      tests_failed++;
      $display("FAIL halt_entry: out=%0d co=%b st=%b, expected 15 1 1", out, co, state_dbg);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd6);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    tests_run++;
    if ({out, sp, co, ovf_err, unf_err, state_dbg} !== {4'd15, 3'd0, 4'b1001}) begin
      tests_failed++;
      $display("FAIL halt_frozen: out=%0d sp=%0d co=%b ovf=%b unf=%b st=%b, expected 15 0 1 0 0 1",
               out, sp, co, ovf_err, unf_err, state_dbg);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int k = 1; k <= 15; k++) tick();
    tests_run++;
    if (w_out !== 4'd15 || w_co !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_at_top: out=%0d co=%b, expected 15 0", w_out, w_co);
    end
    tick();
    tests_run++;
    if (w_out !== 4'd0 || w_co !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_pulse: out=%0d co=%b, expected 0 1", w_out, w_co);
    end
    tick();
    tests_run++;
    if (w_out !== 4'd1 || w_co !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_after: out=%0d co=%b, expected 1 0", w_out, w_co);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd15);
    tick();
    tests_run++;
    if (w_out !== 4'd15 || w_co !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_ld_top: out=%0d co=%b, expected 15 0", w_out, w_co);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    tests_run++;
    if (w_out !== 4'd0 || w_co !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_en_off: out=%0d co=%b, expected 0 0", w_out, w_co);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd15);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd7);
    tick();
    tests_run++;
    if (w_out !== 4'd7 || w_co !== 1'b0 || w_sp !== 3'd1) begin
      tests_failed++;
      $display("FAIL wrap_call_from_top: out=%0d co=%b sp=%0d, expected 7 0 1", w_out, w_co, w_sp);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    tests_run++;
    if (w_out !== 4'd0 || w_co !== 1'b0 || w_sp !== 3'd0) begin
      tests_failed++;
      $display("FAIL wrap_ret_wrapped: out=%0d co=%b sp=%0d, expected 0 0 0", w_out, w_co, w_sp);
    end
  endtask

  task automatic test_nested();
    logic [3:0] exp_out [4];
    logic [2:0] exp_sp [4];
    exp_out = '{4'd8, 4'd12, 4'd9, 4'd3};
    exp_sp  = '{3'd1, 3'd2, 3'd1, 3'd0};
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd8);
        1: drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd12);
        default: drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      endcase
      tick();
      tests_run++;
      if (out !== exp_out[k] || sp !== exp_sp[k]) begin
        tests_failed++;
        $display("FAIL nested_step%0d: out=%0d sp=%0d, expected %0d %0d", k, out, sp, exp_out[k], exp_sp[k]);
      end
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'(k));
      tick();
    end
    tests_run++;
    if (out !== 4'd4 || sp !== 3'd4 || full !== 1'b1 || ovf_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_fill: out=%0d sp=%0d full=%b ovf=%b, expected 4 4 1 0", out, sp, full, ovf_err);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd9);
    tick();
    tests_run++;
    if (out !== 4'd4 || sp !== 3'd4 || full !== 1'b1 || ovf_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_fifth_call: out=%0d sp=%0d full=%b ovf=%b, expected 4 4 1 1", out, sp, full, ovf_err);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    tick();
    tests_run++;
    if (out !== 4'd3 || sp !== 3'd2 || full !== 1'b0 || ovf_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_lifo_pop: out=%0d sp=%0d full=%b ovf=%b, expected 3 2 0 1", out, sp, full, ovf_err);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd11);
    tick();
    tests_run++;
    if (out !== 4'd0 || sp !== 3'd0 || unf_err !== 1'b1 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL unf_ret_empty: out=%0d sp=%0d unf=%b empty=%b, expected 0 0 1 1", out, sp, unf_err, empty);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd10);
    tick();
    tests_run++;
    if (out !== 4'd10 || sp !== 3'd0 || unf_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL unf_sticky_ld: out=%0d sp=%0d unf=%b, expected 10 0 1", out, sp, unf_err);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    tick();
    tests_run++;
    if (out !== 4'd5 || sp !== 3'd1) begin
      tests_failed++;
      $display("FAIL prio_call_wins: out=%0d sp=%0d, expected 5 1", out, sp);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd13);
    tick();
    tests_run++;
    if (out !== 4'd2 || sp !== 3'd0) begin
      tests_failed++;
      $display("FAIL prio_ret_over_ld: out=%0d sp=%0d, expected 2 0", out, sp);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
    tick();
    tests_run++;
    if (out !== 4'd2 || sp !== 3'd0 || ovf_err !== 1'b0 || unf_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_off_hold: out=%0d sp=%0d ovf=%b unf=%b, expected 2 0 0 0", out, sp, ovf_err, unf_err);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd14);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd15);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    tests_run++;
    if (out !== 4'd15 || sp !== 3'd2 || co !== 1'b1 || state_dbg !== 1'b1) begin
      tests_failed++;
      $display("FAIL halt_sp2: out=%0d sp=%0d co=%b st=%b, expected 15 2 1 1", out, sp, co, state_dbg);
    end
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (out !== 4'd0 || sp !== 3'd0 || co !== 1'b0 || state_dbg !== 1'b0 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset: out=%0d sp=%0d co=%b st=%b empty=%b, expected 0 0 0 0 1",
               out, sp, co, state_dbg, empty);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if (out !== 4'd1 || co !== 1'b0 || sp !== 3'd0) begin
      tests_failed++;
      $display("FAIL first_after_reset: out=%0d co=%b sp=%0d, expected 1 0 0", out, co, sp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    #3;
    test_reset();
    test_count_halt();
    test_wrap();
    test_nested();
    test_overflow();
    test_underflow();
    test_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
